vga_compositor_param: RTL and testbench
=======================================

VGA_COMPOSITOR_PARAM -- requirements
Module: vga_compositor_param

Interface
REQ-001 The module SHALL have parameter NUM_LAYERS, default 4, meaning number of prioritised video layers (1..8).
REQ-002 The module SHALL have parameter COLOR_W, default 4, meaning bits per colour channel (RGB width = 3*COLOR_W).
REQ-003 The module SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, and V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning timing in pixels/lines; each total SHALL be <= 1024.
REQ-004 The module SHALL have parameter TICK_DIV, default 4, meaning clock cycles per pixel tick (>= 2).
REQ-005 The module SHALL have parameter BLINK_HALF, default 16666666, meaning clock cycles per blink half-period.
REQ-006 The module SHALL have parameter PORT_BASE, default 8'h40, meaning first port_id of the register window.
REQ-007 Ports SHALL be: clock in 1, system clock; reset in 1, asynchronous active-low reset; in_dato in 8, write data; port_id in 8, write address; write_strobe in 1, write qualifier; layer_on in NUM_LAYERS, per-layer pixel-present flags; layer_rgb in NUM_LAYERS*3*COLOR_W, layer i colour at bits [i*3*COLOR_W +: 3*COLOR_W]; hsync out 1; vsync out 1; video_on out 1; p_tick out 1; pixel_x out 10; pixel_y out 10; frame_start out 1; blink out 1; RGB out 3*COLOR_W.
REQ-008 The module SHALL use one clock, clock; reset is asynchronous and active-low.

Function
REQ-009 p_tick SHALL pulse high for one clock every TICK_DIV clocks, first pulse TICK_DIV clocks after reset release.
REQ-010 pixel_x SHALL advance on p_tick, wrapping from H_TOTAL-1 to 0; pixel_y SHALL advance on that wrap, wrapping from V_TOTAL-1 to 0.
REQ-011 hsync SHALL be low (registered) iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC; vsync likewise on pixel_y with V parameters.
REQ-012 video_on SHALL be high iff pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-013 frame_start SHALL pulse one clock on the p_tick where both counters wrap to (0,0).
REQ-014 Writes: when write_strobe=1, port_id=PORT_BASE+0 loads enable mask, +1 loads blink mask (low NUM_LAYERS bits used), +2 loads background low byte, +3 loads background bits [3*COLOR_W-1:8]; other port_ids ignored.
REQ-015 A blink counter SHALL count to BLINK_HALF-1, then clear and toggle blink; blink is free-running, independent of p_tick.
REQ-016 Layer i is visible iff layer_on[i] & enable[i] & (~blink_mask[i] | blink).
REQ-017 Priority: lowest-index visible layer wins; no visible layer selects background; video_on=0 selects all zeros.
REQ-018 RGB SHALL be registered, updated only on p_tick from the selection of REQ-017 using current inputs (latency one pixel tick).
REQ-019 Simultaneous write to same register in same cycle as frame_start: the new value SHALL be captured and applied per REQ-024.

Reset
REQ-020 On reset low: counters, pixel_x, pixel_y, p_tick, frame_start, blink, RGB = 0; hsync = vsync = 1; video_on = 1 (position 0,0).
REQ-021 On reset low: enable mask = all ones, blink mask = 0, background = 0, shadow copies equal active copies.
REQ-022 Reset asserted mid-frame SHALL return all state to REQ-020/021 values immediately, without waiting for clock.

Configuration
REQ-023 Macro COMPOSITOR_SHADOW_EN SHALL select register update policy.
REQ-024 With COMPOSITOR_SHADOW_EN defined, writes SHALL go to shadow registers copied to active registers on frame_start only (no tearing); without it, writes SHALL update active registers on the clock after write_strobe.

Verification
REQ-025 Defaults, reset release -> p_tick every 4 clocks; hsync low for pixel_x 656..751; vsync low for pixel_y 490..491; frame_start every 800*525*4 = 1680000 clocks.
REQ-026 layer_on=4'b0110, layer1 rgb=12'hF00, layer2 rgb=12'h0F0, video_on=1 -> RGB=12'hF00 after next p_tick; write 8'h0D to port 8'h40 -> layer2 wins, RGB=12'h0F0.
REQ-027 Blink mask 8'h01 written, only layer0 on with 12'h00F, background 12'h123 -> RGB alternates 12'h00F/12'h123 every BLINK_HALF clocks (BLINK_HALF=100 in bench).
REQ-028 With COMPOSITOR_SHADOW_EN, write 8'h00 to port 8'h40 mid-frame -> RGB unchanged until frame_start, then background; without macro -> background from next p_tick.
REQ-029 Pixel in blanking (pixel_x=700) with layer_on all ones -> RGB=12'h000.
REQ-030 reset pulsed low at pixel_y=200 -> outputs match REQ-020 asynchronously; registers match REQ-021.

Source files
------------

// File: rtl/vga_compositor_param.sv
// vga_compositor_param
//   VGA timing generator with a prioritised multi-layer colour compositor.
//   The pixel tick is one clock in TICK_DIV. The pixel counters advance on that
//   tick, and hsync/vsync are registered so they line up with pixel_x/pixel_y.
//   RGB is registered on the pixel tick from the layer selection for the
//   current position, so RGB shows the previous pixel (one tick of latency).
//   The layer with the lowest index that is visible wins. A position outside
//   the active area gives all zeros.
//
//   Write register window, addressed by port_id relative to PORT_BASE:
//     +0  enable mask     (low NUM_LAYERS bits)
//     +1  blink mask      (low NUM_LAYERS bits)
//     +2  background      bits [7:0]
//     +3  background      bits [3*COLOR_W-1:8]
//
//   Optional feature macro: COMPOSITOR_SHADOW_EN
//     defined   : writes land in shadow registers. These are copied to the
//                 active set in the clock after frame_start.
//     undefined : writes update the active set directly.
//
//   Ports
//     clock, reset (async active-low)
//     in_dato/port_id/write_strobe   register write bus
//     layer_on, layer_rgb            per-layer presence flag and colour
//     hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_start, blink, RGB
module vga_compositor_param #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned BLINK_HALF = 16666666,
  parameter logic [7:0]  PORT_BASE  = 8'h40
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [7:0]                      in_dato,
  input  logic [7:0]                      port_id,
  input  logic                            write_strobe,
  input  logic [NUM_LAYERS-1:0]           layer_on,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            video_on,
  output logic                            p_tick,
  output logic [9:0]                      pixel_x,
  output logic [9:0]                      pixel_y,
  output logic                            frame_start,
  output logic                            blink,
  output logic [3*COLOR_W-1:0]            RGB
);

  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [9:0]         H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]         V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0]        H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0]        HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]        HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]        V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0]        VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]        VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]         ADDR_EN    = PORT_BASE;
  localparam logic [7:0]         ADDR_BM    = PORT_BASE + 8'd1;
  localparam logic [7:0]         ADDR_BG_LO = PORT_BASE + 8'd2;
  localparam logic [7:0]         ADDR_BG_HI = PORT_BASE + 8'd3;

  // Timing state
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               tick_en;
  logic [9:0]         pixel_x_q, pixel_x_d;
  logic [9:0]         pixel_y_q, pixel_y_d;
  logic               h_wrap, v_wrap;
  logic               p_tick_q, p_tick_d;
  logic               frame_start_q, frame_start_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_c;

  // Blink state
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_wrap;
  logic               blink_q, blink_d;

  // Active register set and write-merge values
  logic [NUM_LAYERS-1:0] en_q, en_d, en_wr, en_src;
  logic [NUM_LAYERS-1:0] bm_q, bm_d, bm_wr, bm_src;
  logic [RGB_W-1:0]      bg_q, bg_d, bg_wr, bg_src;
`ifdef COMPOSITOR_SHADOW_EN
  logic [NUM_LAYERS-1:0] en_sh_q, en_sh_d;
  logic [NUM_LAYERS-1:0] bm_sh_q, bm_sh_d;
  logic [RGB_W-1:0]      bg_sh_q, bg_sh_d;
`endif

  // Compositor
  logic [NUM_LAYERS-1:0] vis;
  logic [RGB_W-1:0]      sel;
  logic                  found;
  logic [RGB_W-1:0]      rgb_q, rgb_d;

  // Pixel tick, counters and sync generation
  always_comb begin
    tick_en       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d    = tick_en ? '0 : tick_cnt_q + TICK_W'(1);
    h_wrap        = (pixel_x_q == H_LAST);
    v_wrap        = (pixel_y_q == V_LAST);
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    if (tick_en) begin
      pixel_x_d = h_wrap ? '0 : pixel_x_q + 10'd1;
      if (h_wrap) begin
        pixel_y_d = v_wrap ? '0 : pixel_y_q + 10'd1;
      end
    end
    p_tick_d      = tick_en;
    frame_start_d = tick_en & h_wrap & v_wrap;
    // Sync is decoded from the next position, so the registered sync
    // changes on the same edge as the counters.
    hsync_d = !(({1'b0, pixel_x_d} >= HS_START) && ({1'b0, pixel_x_d} < HS_END));
    vsync_d = !(({1'b0, pixel_y_d} >= VS_START) && ({1'b0, pixel_y_d} < VS_END));
    video_on_c = ({1'b0, pixel_x_q} < H_ACT) && ({1'b0, pixel_y_q} < V_ACT);
  end

  // Free-running blink
  always_comb begin
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q ^ blink_wrap;
  end

  // Register writes: merge onto the shadow set when it exists, otherwise
  // onto the active set.
  always_comb begin
`ifdef COMPOSITOR_SHADOW_EN
    en_src = en_sh_q;
    bm_src = bm_sh_q;
    bg_src = bg_sh_q;
`else
    en_src = en_q;
    bm_src = bm_q;
    bg_src = bg_q;
`endif
    en_wr = en_src;
    bm_wr = bm_src;
    bg_wr = bg_src;
    if (write_strobe && (port_id == ADDR_EN)) en_wr = in_dato[NUM_LAYERS-1:0];
    if (write_strobe && (port_id == ADDR_BM)) bm_wr = in_dato[NUM_LAYERS-1:0];
    for (int unsigned b = 0; b < RGB_W; b++) begin
      if (b < 8) begin
        if (write_strobe && (port_id == ADDR_BG_LO)) bg_wr[b] = in_dato[b[2:0]];
      end else if (b < 16) begin
        if (write_strobe && (port_id == ADDR_BG_HI)) bg_wr[b] = in_dato[b[2:0]];
      end
    end
`ifdef COMPOSITOR_SHADOW_EN
    en_sh_d = en_wr;
    bm_sh_d = bm_wr;
    bg_sh_d = bg_wr;
    // The copy takes the merged value. A write in the frame_start cycle
    // therefore reaches the active set in that same frame.
    en_d = frame_start_q ? en_wr : en_q;
    bm_d = frame_start_q ? bm_wr : bm_q;
    bg_d = frame_start_q ? bg_wr : bg_q;
`else
    en_d = en_wr;
    bm_d = bm_wr;
    bg_d = bg_wr;
`endif
  end

  // Layer selection: scan upward and keep the first visible layer.
  always_comb begin
    vis   = layer_on & en_q & (~bm_q | {NUM_LAYERS{blink_q}});
    sel   = bg_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && vis[i]) begin
        sel   = layer_rgb[i*RGB_W +: RGB_W];
        found = 1'b1;
      end
    end
    if (!video_on_c) sel = '0;
    rgb_d = tick_en ? sel : rgb_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q    <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      p_tick_q      <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      en_q          <= '1;
      bm_q          <= '0;
      bg_q          <= '0;
      rgb_q         <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      p_tick_q      <= p_tick_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      en_q          <= en_d;
      bm_q          <= bm_d;
      bg_q          <= bg_d;
      rgb_q         <= rgb_d;
    end
  end

`ifdef COMPOSITOR_SHADOW_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_sh_q <= '1;
      bm_sh_q <= '0;
      bg_sh_q <= '0;
    end else begin
      en_sh_q <= en_sh_d;
      bm_sh_q <= bm_sh_d;
      bg_sh_q <= bg_sh_d;
    end
  end
`endif

  always_comb begin
    hsync       = hsync_q;
    vsync       = vsync_q;
    video_on    = video_on_c;
    p_tick      = p_tick_q;
    pixel_x     = pixel_x_q;
    pixel_y     = pixel_y_q;
    frame_start = frame_start_q;
    blink       = blink_q;
    RGB         = rgb_q;
  end

endmodule

// File: tb/tb_vga_compositor_param.sv
// tb_vga_compositor_param
//   Directed bench for vga_compositor_param. It uses a reduced raster:
//   24x12 total, 16x8 active, hsync at x 18..21, vsync at y 9..10,
//   TICK_DIV 4, BLINK_HALF 100. A clock count since reset release gives the
//   expected raster position. All checking is done on the falling edge.
module tb_vga_compositor_param;

  localparam int unsigned NL = 4, CW = 4, TD = 4, BH = 100;
  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME_TICKS = HT * VT;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [7:0]            in_dato, port_id;
  logic                  write_strobe;
  logic [NL-1:0]         layer_on;
  logic [NL*3*CW-1:0]    layer_rgb;
  logic                  hsync, vsync, video_on, p_tick, frame_start, blink;
  logic [9:0]            pixel_x, pixel_y;
  logic [3*CW-1:0]       RGB;

  int unsigned cyc;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  vga_compositor_param #(
    .NUM_LAYERS(NL), .COLOR_W(CW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TICK_DIV(TD), .BLINK_HALF(BH), .PORT_BASE(8'h40)
  ) dut (
    .clock(clk), .reset(rst_n), .in_dato(in_dato), .port_id(port_id),
    .write_strobe(write_strobe), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .blink(blink), .RGB(RGB)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int unsigned ticks();
    return cyc / TD;
  endfunction
  function automatic bit ptick_m();
    return (cyc > 0) && (cyc % TD == 0);
  endfunction
  function automatic int unsigned mx(input int unsigned t);
    return t % HT;
  endfunction
  function automatic int unsigned my(input int unsigned t);
    return (t / HT) % VT;
  endfunction
  function automatic bit prev_active();
    int unsigned t;
    t = ticks();
    if (t == 0) return 1'b0;
    return (mx(t - 1) < HA) && (my(t - 1) < VA);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    port_id = p; in_dato = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic wait_active_tick(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (ptick_m() && prev_active()) ok = 1'b1;
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_prev_pixel(input int unsigned px, input int unsigned py, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (ptick_m() && mx(ticks() - 1) == px && my(ticks() - 1) == py) ok = 1'b1;
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_frame(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (ptick_m() && (ticks() % FRAME_TICKS == 0)) ok = 1'b1;
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    else     check({tag, "_frame_start"}, 32'(frame_start), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_pixel_x"},     32'(pixel_x), 32'd0);
    check({tag, "_pixel_y"},     32'(pixel_y), 32'd0);
    check({tag, "_p_tick"},      32'(p_tick), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_blink"},       32'(blink), 32'd0);
    check({tag, "_rgb"},         32'(RGB), 32'd0);
    check({tag, "_hsync"},       32'(hsync), 32'd1);
    check({tag, "_vsync"},       32'(vsync), 32'd1);
    check({tag, "_video_on"},    32'(video_on), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, x, y;
    logic [11:0] exp_rgb;
    in_dato = '0; port_id = '0; write_strobe = 1'b0;
    layer_on = '0; layer_rgb = '0;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // Timing over one full frame plus a little more
    repeat (1200) begin
      step();
      t = ticks(); x = mx(t); y = my(t);
      check("p_tick",      32'(p_tick), 32'(ptick_m()));
      check("pixel_x",     32'(pixel_x), x);
      check("pixel_y",     32'(pixel_y), y);
      check("hsync",       32'(hsync), 32'(!(x >= 18 && x < 22)));
      check("vsync",       32'(vsync), 32'(!(y >= 9 && y < 11)));
      check("video_on",    32'(video_on), 32'(x < HA && y < VA));
      check("frame_start", 32'(frame_start), 32'(ptick_m() && (t % FRAME_TICKS == 0)));
      check("blink",       32'(blink), (cyc / BH) % 2);
    end

    // Priority: layers 1 and 2 present, layer 1 wins until it is disabled
    layer_rgb[0*12 +: 12] = 12'h00F;
    layer_rgb[1*12 +: 12] = 12'hF00;
    layer_rgb[2*12 +: 12] = 12'h0F0;
    layer_rgb[3*12 +: 12] = 12'hFFF;
    layer_on = 4'b0110;
    wait_active_tick("prio");
    check("prio_l1", 32'(RGB), 32'h0F00);
    wr(8'h40, 8'h0D);
`ifdef COMPOSITOR_SHADOW_EN
    wait_active_tick("prio_hold");
    check("prio_shadow_hold", 32'(RGB), 32'h0F00);
    wait_frame("prio");
`endif
    wait_active_tick("prio2");
    check("prio_l2", 32'(RGB), 32'h00F0);
    wr(8'h44, 8'h00);
`ifdef COMPOSITOR_SHADOW_EN
    wait_frame("badport");
`endif
    wait_active_tick("badport");
    check("bad_port_ignored", 32'(RGB), 32'h00F0);

    // Blink: layer0 blinks over background 0x123
    wr(8'h41, 8'h01);
    wr(8'h40, 8'h0F);
    wr(8'h42, 8'h23);
    wr(8'h43, 8'h01);
    layer_on = 4'b0001;
`ifdef COMPOSITOR_SHADOW_EN
    wait_frame("blink");
`endif
    repeat (60) begin
      wait_active_tick("blink");
      exp_rgb = (((cyc - 1) / BH) % 2 == 1) ? 12'h00F : 12'h123;
      check("blink_rgb", 32'(RGB), 32'(exp_rgb));
    end

    // Disabling every layer mid-frame falls back to the background
    wr(8'h41, 8'h00);
`ifdef COMPOSITOR_SHADOW_EN
    wait_frame("nobm");
`endif
    wait_active_tick("nobm");
    check("nobm_l0", 32'(RGB), 32'h000F);
    wr(8'h40, 8'h00);
`ifdef COMPOSITOR_SHADOW_EN
    wait_active_tick("dis_hold");
    check("disable_shadow_hold", 32'(RGB), 32'h000F);
    wait_frame("dis");
`endif
    wait_active_tick("dis");
    check("bg_after_disable", 32'(RGB), 32'h0123);

    // Blanking outputs black even with every layer present
    wr(8'h40, 8'h0F);
    layer_on = 4'hF;
`ifdef COMPOSITOR_SHADOW_EN
    wait_frame("blank");
`endif
    wait_prev_pixel(20, 2, "hblank");
    check("hblank_black", 32'(RGB), 32'h0000);
    wait_prev_pixel(3, 9, "vblank");
    check("vblank_black", 32'(RGB), 32'h0000);
    wait_active_tick("blank_act");
    check("active_l0", 32'(RGB), 32'h000F);

    // Asynchronous reset in the middle of a frame
    wr(8'h40, 8'h02);
    wr(8'h41, 8'h01);
    wr(8'h42, 8'h23);
    wr(8'h43, 8'h01);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
        step();
        if (my(ticks()) == 5) ok = 1'b1;
      end
      if (!ok) check("midrst_timeout", 32'd0, 32'd1);
    end
    check("pre_rst_pixel_y", 32'(pixel_y), 32'd5);
    #2 rst_n = 1'b0;
    #1 chk_reset("amid");
    layer_on = 4'b0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_active_tick("post_rst");
    check("post_rst_en_bm", 32'(RGB), 32'h000F);
    layer_on = 4'b0000;
    wait_active_tick("post_rst_bg");
    check("post_rst_bg", 32'(RGB), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
